// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO drain-side stream front-end.
package fifo_rd_stream_pkg;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_BODY = 1'b1
    } pkt_state_e;

    localparam int OCC_W = 2;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready skid buffer: push captures din at the tail, pop retires the head.
module stream_skid2
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [OCC_W-1:0] occ_r;
    logic             pop_s;
    logic             push_s;

    // Ignore pops from an empty buffer and pushes that would overflow it.
    assign pop_s  = pop & (occ_r != OCC_W'(0));
    assign push_s = push & ((occ_r != OCC_W'(2)) | pop_s);

    // Head always holds the oldest entry; tail is only meaningful at occupancy 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= '0;
            tail_r <= '0;
            occ_r  <= '0;
        end else if (clr) begin
            occ_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_r == OCC_W'(0)) begin
                        head_r <= din;
                    end else begin
                        tail_r <= din;
                    end
                    occ_r <= occ_r + OCC_W'(1);
                end
                2'b01: begin
                    head_r <= tail_r;
                    occ_r  <= occ_r - OCC_W'(1);
                end
                2'b11: begin
                    if (occ_r == OCC_W'(2)) begin
                        head_r <= tail_r;
                        tail_r <= din;
                    end else begin
                        head_r <= din;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign occ  = occ_r;
    assign dout = head_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream framed into fixed-length packets.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PKTLEN_W = 8,
    parameter int PKTCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                flush,
    input  logic [PKTLEN_W-1:0] pktlen,
    input  logic                notempty,
    input  logic [WIDTH-1:0]    fifodout,
    output logic                fiford,
    output logic                fifoflsh,
    output logic                m_valid,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_last,
    input  logic                m_ready,
    output logic [PKTCNT_W-1:0] pkt_cnt,
    output logic                idle
);

    logic [OCC_W-1:0]    occ_s;
    logic                inflight_r;
    pkt_state_e          state_r;
    logic [PKTLEN_W-1:0] beat_cnt_r;
    logic [PKTLEN_W-1:0] plen_r;
    logic [PKTCNT_W-1:0] pkt_cnt_r;
    logic [PKTLEN_W-1:0] plen_eff_s;
    logic                pop_s;
    logic                capture_s;
    logic                room_s;
    logic                last_s;

    assign pop_s     = m_valid & m_ready;
    // A read may issue when the buffer plus the in-flight word leaves a slot, or one is freed now.
    assign room_s    = ((occ_s + OCC_W'(inflight_r)) < OCC_W'(2)) | pop_s;
    assign fiford    = ~rst & enable & notempty & ~flush & room_s;
    assign fifoflsh  = flush;
    assign capture_s = inflight_r & ~flush;

    assign m_valid    = (occ_s != OCC_W'(0));
    assign idle       = (occ_s == OCC_W'(0)) & ~inflight_r;
    assign plen_eff_s = (pktlen == '0) ? PKTLEN_W'(1) : pktlen;
    assign last_s     = (state_r == PKT_IDLE) ? (plen_eff_s == PKTLEN_W'(1))
                                              : (beat_cnt_r == plen_r - PKTLEN_W'(1));
    assign m_last     = m_valid & last_s;
    assign pkt_cnt    = pkt_cnt_r;

    stream_skid2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .push (capture_s),
        .din  (fifodout),
        .pop  (pop_s),
        .occ  (occ_s),
        .dout (m_data)
    );

    // Tracks whether the FIFO read data is valid this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
        end else if (flush) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= fiford;
        end
    end

    // Packet framing: length is latched on the first beat so mid-packet pktlen edits wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= PKT_IDLE;
            beat_cnt_r <= '0;
            plen_r     <= '0;
            pkt_cnt_r  <= '0;
        end else if (flush) begin
            state_r    <= PKT_IDLE;
            beat_cnt_r <= '0;
        end else if (pop_s) begin
            case (state_r)
                PKT_IDLE: begin
                    plen_r <= plen_eff_s;
                    if (plen_eff_s == PKTLEN_W'(1)) begin
                        pkt_cnt_r <= pkt_cnt_r + PKTCNT_W'(1);
                    end else begin
                        beat_cnt_r <= PKTLEN_W'(1);
                        state_r    <= PKT_BODY;
                    end
                end
                PKT_BODY: begin
                    if (last_s) begin
                        pkt_cnt_r  <= pkt_cnt_r + PKTCNT_W'(1);
                        beat_cnt_r <= '0;
                        state_r    <= PKT_IDLE;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + PKTLEN_W'(1);
                    end
                end
                default: begin
                    beat_cnt_r <= '0;
                    state_r    <= PKT_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a cycle table for streaming, plus hand-built corner sequences.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  pktlen = 8'd4;
    logic        notempty;
    logic [7:0]  fifodout = 8'h00;
    logic        fiford;
    logic        fifoflsh;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic [15:0] pkt_cnt;
    logic        idle;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .WIDTH    (8),
        .PKTLEN_W (8),
        .PKTCNT_W (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .flush    (flush),
        .pktlen   (pktlen),
        .notempty (notempty),
        .fifodout (fifodout),
        .fiford   (fiford),
        .fifoflsh (fifoflsh),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .pkt_cnt  (pkt_cnt),
        .idle     (idle)
    );

    // FIFO model: registered read data, holds between reads, flush empties it.
    logic [7:0] mem [0:31];
    logic [5:0] wr_ptr = 6'd0;
    logic [5:0] rd_ptr = 6'd0;
    assign notempty = (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (fifoflsh) begin
            rd_ptr <= wr_ptr;
        end else if (fiford) begin
            fifodout <= mem[rd_ptr[4:0]];
            rd_ptr   <= rd_ptr + 6'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[4:0]] = base + 8'(i);
            wr_ptr = wr_ptr + 6'd1;
        end
    endtask

    // Stream-rule monitor: occupancy model, read-issue room, stall stability.
    int         occ_m = 0;
    int         inflight_m = 0;
    logic       mon_en = 1'b0;
    logic       stall_m = 1'b0;
    logic [7:0] sd_m = 8'h00;
    logic       sl_m = 1'b0;
    logic       pop_w;
    assign pop_w = m_valid & m_ready;

    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_vs_occ", 32'(m_valid), 32'(occ_m != 0));
            check("rd_room", 32'(fiford & ((occ_m + inflight_m) >= 2) & ~pop_w), 32'd0);
            if (stall_m) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(sd_m));
                check("stall_last", 32'(m_last), 32'(sl_m));
            end
            stall_m <= m_valid & ~m_ready & ~flush & ~rst;
            sd_m    <= m_data;
            sl_m    <= m_last;
            if (rst | flush) begin
                occ_m      <= 0;
                inflight_m <= 0;
            end else begin
                occ_m      <= occ_m + inflight_m - 32'(pop_w);
                inflight_m <= 32'(fiford);
            end
        end
    end

    logic [7:0] exp_data [0:15];
    logic       exp_last [0:15];
    int         exp_n;

    task automatic set_exp(input logic [7:0] base, input int n, input int plen);
        exp_n = n;
        for (int i = 0; i < n; i++) begin
            exp_data[i] = base + 8'(i);
            exp_last[i] = ((i % plen) == plen - 1);
        end
    endtask

    task automatic drain_check(input string tag, input int start, input int budget, input logic [3:0] pat);
        int idx;
        int cyc;
        idx = start;
        cyc = 0;
        while (idx < exp_n && cyc < budget) begin
            m_ready = pat[cyc[1:0]];
            #3;
            if (m_valid && m_ready) begin
                check($sformatf("%s_data%0d", tag, idx), 32'(m_data), 32'(exp_data[idx]));
                check($sformatf("%s_last%0d", tag, idx), 32'(m_last), 32'(exp_last[idx]));
                idx++;
            end
            cyc++;
            tick();
        end
        check($sformatf("%s_beats", tag), 32'(idx), 32'(exp_n));
    endtask

    typedef struct {
        int          ld_n;
        logic [7:0]  ld_base;
        logic        en;
        logic        rdy;
        logic [7:0]  plen;
        logic        e_rd;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_last;
        logic [15:0] e_cnt;
        logic        e_idle;
    } vec_t;

    vec_t vecs [0:16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx_e;

        // Continuous drain of 0x01..0x08 with pktlen=4, then three single-beat packets with pktlen=0.
        vecs[0]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
        vecs[1]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[2]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'h01, 1'b0, 16'd0, 1'b0};
        vecs[3]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'h02, 1'b0, 16'd0, 1'b0};
        vecs[4]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'h03, 1'b0, 16'd0, 1'b0};
        vecs[5]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'h04, 1'b1, 16'd0, 1'b0};
        vecs[6]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'h05, 1'b0, 16'd1, 1'b0};
        vecs[7]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'h06, 1'b0, 16'd1, 1'b0};
        vecs[8]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 8'h07, 1'b0, 16'd1, 1'b0};
        vecs[9]  = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 8'h08, 1'b1, 16'd1, 1'b0};
        vecs[10] = '{0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2, 1'b1};
        vecs[11] = '{3, 8'h21, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd2, 1'b1};
        vecs[12] = '{0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd2, 1'b0};
        vecs[13] = '{0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 8'h21, 1'b1, 16'd2, 1'b0};
        vecs[14] = '{0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 8'h22, 1'b1, 16'd3, 1'b0};
        vecs[15] = '{0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 8'h23, 1'b1, 16'd4, 1'b0};
        vecs[16] = '{0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd5, 1'b1};

        // Reset values
        tick();
        tick();
        #3;
        check("rst_fiford", 32'(fiford), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_pktcnt", 32'(pkt_cnt), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        m_ready = 1'b1;
        load(8'h01, 8);
        #3;
        check("preload_disabled_rd", 32'(fiford), 32'd0);
        tick();

        for (int i = 0; i < 17; i++) begin
            load(vecs[i].ld_base, vecs[i].ld_n);
            enable  = vecs[i].en;
            m_ready = vecs[i].rdy;
            pktlen  = vecs[i].plen;
            #3;
            check($sformatf("v%0d_rd", i), 32'(fiford), 32'(vecs[i].e_rd));
            check($sformatf("v%0d_valid", i), 32'(m_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_cnt", i), 32'(pkt_cnt), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_idle", i), 32'(idle), 32'(vecs[i].e_idle));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_data", i), 32'(m_data), 32'(vecs[i].e_data));
                check($sformatf("v%0d_last", i), 32'(m_last), 32'(vecs[i].e_last));
            end
            tick();
        end

        // Backpressure: ready pattern 1,0,0,1 over six words, pktlen=3
        pktlen = 8'd3;
        load(8'h31, 6);
        set_exp(8'h31, 6, 3);
        drain_check("bp", 0, 60, 4'b1001);
        check("bp_cnt", 32'(pkt_cnt), 32'd7);
        check("bp_idle", 32'(idle), 32'd1);

        // Flush after two of four beats with one read in flight
        pktlen = 8'd4;
        m_ready = 1'b1;
        load(8'h41, 6);
        #3;
        tick();
        #3;
        tick();
        #3;
        check("fl_b1_valid", 32'(m_valid), 32'd1);
        check("fl_b1_data", 32'(m_data), 32'h41);
        tick();
        #3;
        check("fl_b2_data", 32'(m_data), 32'h42);
        tick();
        m_ready = 1'b0;
        flush = 1'b1;
        #3;
        check("fl_fifoflsh", 32'(fifoflsh), 32'd1);
        check("fl_fiford", 32'(fiford), 32'd0);
        tick();
        flush = 1'b0;
        #3;
        check("fl_after_valid", 32'(m_valid), 32'd0);
        check("fl_after_idle", 32'(idle), 32'd1);
        check("fl_after_cnt", 32'(pkt_cnt), 32'd7);
        check("fl_after_fifoflsh", 32'(fifoflsh), 32'd0);
        tick();
        load(8'h51, 4);
        set_exp(8'h51, 4, 4);
        drain_check("fl_next", 0, 20, 4'b1111);
        check("fl_next_cnt", 32'(pkt_cnt), 32'd8);

        // Enable gating: buffered words drain with enable low, rest follow once raised
        pktlen = 8'd5;
        m_ready = 1'b0;
        load(8'h61, 5);
        set_exp(8'h61, 5, 5);
        #3;
        tick();
        #3;
        tick();
        enable = 1'b0;
        #3;
        check("en_off_rd_a", 32'(fiford), 32'd0);
        tick();
        idx_e = 0;
        for (int k = 0; k < 4; k++) begin
            m_ready = 1'b1;
            #3;
            check($sformatf("en_off_rd%0d", k), 32'(fiford), 32'd0);
            if (m_valid && m_ready) begin
                check($sformatf("en_off_data%0d", idx_e), 32'(m_data), 32'(exp_data[idx_e]));
                check($sformatf("en_off_last%0d", idx_e), 32'(m_last), 32'(exp_last[idx_e]));
                idx_e++;
            end
            tick();
        end
        check("en_off_drained", 32'(idx_e), 32'd2);
        check("en_off_valid", 32'(m_valid), 32'd0);
        enable = 1'b1;
        drain_check("en_on", idx_e, 30, 4'b1111);
        check("en_on_cnt", 32'(pkt_cnt), 32'd9);

        // Reset mid-packet with two words buffered
        pktlen = 8'd4;
        m_ready = 1'b0;
        load(8'h71, 6);
        #3;
        tick();
        #3;
        tick();
        m_ready = 1'b1;
        #3;
        check("mr_pre_data", 32'(m_data), 32'h71);
        tick();
        m_ready = 1'b0;
        #3;
        tick();
        rst = 1'b1;
        m_ready = 1'b1;
        #3;
        check("mr_hold_rd", 32'(fiford), 32'd0);
        tick();
        #3;
        check("mr_valid", 32'(m_valid), 32'd0);
        check("mr_cnt", 32'(pkt_cnt), 32'd0);
        check("mr_idle", 32'(idle), 32'd1);
        check("mr_rd", 32'(fiford), 32'd0);
        tick();
        rst = 1'b0;
        pktlen = 8'd3;
        set_exp(8'h74, 3, 3);
        drain_check("mr_post", 0, 20, 4'b1111);
        check("mr_post_cnt", 32'(pkt_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
